axi4lite_cmd_bridge: RTL and testbench

Parametrised AXI4-Lite transaction engine: a single-outstanding command port drives an internal AXI4-Lite master FSM, which talks to an internal AXI4-Lite slave register bank. Word width, address width, bank depth and slave wait states are configurable. Adds write strobes, an ID register, SLVERR responses and a backpressured response channel. It sits behind the Tiny Tapeout top-level pin mapping and replaces the fixed 8-bit, 4-entry start/done transfer path.

---
 rtl/axi4lite_cmd_bridge_if.sv | 28 ++
 rtl/axi4lite_cmd_bridge.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_axi4lite_cmd_bridge.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4lite_cmd_bridge_if.sv
// Command/response channel bundle for axi4lite_cmd_bridge.
// The slave modport is the bridge side; the master modport is the command issuer.
interface axi4lite_cmd_bridge_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32
);
   logic                    cmd_valid;
   logic                    cmd_ready;
   logic                    cmd_write;
   logic [ADDR_WIDTH-1:0]   cmd_addr;
   logic [DATA_WIDTH-1:0]   cmd_wdata;
   logic [DATA_WIDTH/8-1:0] cmd_wstrb;
   logic                    rsp_valid;
   logic                    rsp_ready;
   logic                    rsp_write;
   logic [1:0]              rsp_resp;
   logic [DATA_WIDTH-1:0]   rsp_rdata;

   modport slave (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
      output cmd_ready, rsp_valid, rsp_write, rsp_resp, rsp_rdata
   );

   modport master (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_write, rsp_resp, rsp_rdata
   );
endinterface

// File: rtl/axi4lite_cmd_bridge.sv
// Single-outstanding command port -> internal AXI4-Lite master FSM -> internal AXI4-Lite register bank.
// Optional byte-lane strobes are enabled by defining AXI4LITE_STRB_EN.
module axi4lite_cmd_bridge #(
   parameter int          ADDR_WIDTH  = 4,
   parameter int          DATA_WIDTH  = 32,
   parameter int          REG_COUNT   = 12,
   parameter int          WAIT_CYCLES = 0,
   parameter logic [31:0] ID_VALUE    = 32'hA41C_0001
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ena,
   output logic                  busy,
   axi4lite_cmd_bridge_if.slave  bus
);
   localparam int                    STRB_WIDTH  = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH:0]   REG_LIMIT   = (ADDR_WIDTH + 1)'(REG_COUNT);
   localparam logic [3:0]            WAIT_LOAD   = 4'(WAIT_CYCLES);
   localparam logic [DATA_WIDTH-1:0] ID_WORD     = DATA_WIDTH'(ID_VALUE);
   localparam logic [1:0]            RESP_OKAY   = 2'b00;
   localparam logic [1:0]            RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_t;

   // Internal AXI4-Lite bus between master FSM and register bank
   logic                  awvalid, awready, wvalid, wready, bvalid, bready;
   logic                  arvalid, arready, rvalid, rready;
   logic [ADDR_WIDTH-1:0] awaddr, araddr;
   logic [DATA_WIDTH-1:0] wdata, rdata;
   logic [STRB_WIDTH-1:0] wstrb;
   logic [1:0]            bresp, rresp;

   // Master state
   state_t                state_q, state_d;
   logic                  aw_done_q, aw_done_d, w_done_q, w_done_d;
   logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
   logic [DATA_WIDTH-1:0] req_wdata_q, req_wdata_d;
   logic [STRB_WIDTH-1:0] req_wstrb_q, req_wstrb_d;
   logic                  rsp_write_q, rsp_write_d;
   logic [1:0]            rsp_resp_q, rsp_resp_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic [STRB_WIDTH-1:0] cmd_strb_sel;

`ifdef AXI4LITE_STRB_EN
   assign cmd_strb_sel = bus.cmd_wstrb;
`else
   logic unused_cmd_wstrb;
   assign cmd_strb_sel     = '1;
   assign unused_cmd_wstrb = ^bus.cmd_wstrb;
`endif

   assign bus.cmd_ready = ena && (state_q == IDLE);
   assign bus.rsp_valid = (state_q == RSP);
   assign bus.rsp_write = rsp_write_q;
   assign bus.rsp_resp  = rsp_resp_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign busy          = (state_q != IDLE);

   assign awaddr = req_addr_q;
   assign araddr = req_addr_q;
   assign wdata  = req_wdata_q;
   assign wstrb  = req_wstrb_q;

   always_comb begin
      state_d     = state_q;
      aw_done_d   = aw_done_q;
      w_done_d    = w_done_q;
      req_addr_d  = req_addr_q;
      req_wdata_d = req_wdata_q;
      req_wstrb_d = req_wstrb_q;
      rsp_write_d = rsp_write_q;
      rsp_resp_d  = rsp_resp_q;
      rsp_rdata_d = rsp_rdata_q;
      awvalid     = 1'b0;
      wvalid      = 1'b0;
      bready      = 1'b0;
      arvalid     = 1'b0;
      rready      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (ena && bus.cmd_valid) begin
               req_addr_d  = bus.cmd_addr;
               req_wdata_d = bus.cmd_wdata;
               req_wstrb_d = cmd_strb_sel;
               aw_done_d   = 1'b0;
               w_done_d    = 1'b0;
               state_d     = bus.cmd_write ? WR_REQ : RD_REQ;
            end
         end
         WR_REQ: begin
            // AW and W retire independently; leave once both have handshaken
            awvalid = !aw_done_q;
            wvalid  = !w_done_q;
            if (awvalid && awready) aw_done_d = 1'b1;
            if (wvalid && wready)   w_done_d  = 1'b1;
            if (aw_done_d && w_done_d) state_d = WR_RESP;
         end
         WR_RESP: begin
            bready = 1'b1;
            if (bvalid) begin
               rsp_write_d = 1'b1;
               rsp_resp_d  = bresp;
               rsp_rdata_d = '0;
               state_d     = RSP;
            end
         end
         RD_REQ: begin
            arvalid = 1'b1;
            if (arready) state_d = RD_DATA;
         end
         RD_DATA: begin
            rready = 1'b1;
            if (rvalid) begin
               rsp_write_d = 1'b0;
               rsp_resp_d  = rresp;
               rsp_rdata_d = rdata;
               state_d     = RSP;
            end
         end
         RSP: begin
            if (bus.rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         req_addr_q  <= '0;
         req_wdata_q <= '0;
         req_wstrb_q <= '0;
         rsp_write_q <= 1'b0;
         rsp_resp_q  <= RESP_OKAY;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         aw_done_q   <= aw_done_d;
         w_done_q    <= w_done_d;
         req_addr_q  <= req_addr_d;
         req_wdata_q <= req_wdata_d;
         req_wstrb_q <= req_wstrb_d;
         rsp_write_q <= rsp_write_d;
         rsp_resp_q  <= rsp_resp_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   // Register bank (slave side); word 0 is the read-only ID
   logic [DATA_WIDTH-1:0] regs_q [1:REG_COUNT-1];
   logic [DATA_WIDTH-1:0] regs_d [1:REG_COUNT-1];
   logic                  aw_cap_q, aw_cap_d, w_cap_q, w_cap_d;
   logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d, ar_addr_q, ar_addr_d;
   logic [DATA_WIDTH-1:0] w_data_q, w_data_d, rdata_q, rdata_d;
   logic [STRB_WIDTH-1:0] w_strb_q, w_strb_d;
   logic [3:0]            wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
   logic                  bvalid_q, bvalid_d, rvalid_q, rvalid_d;
   logic                  rd_pend_q, rd_pend_d;
   logic [1:0]            bresp_q, bresp_d, rresp_q, rresp_d;
   logic                  wr_fire, rd_fire, wr_err, rd_err;
   logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
   logic [DATA_WIDTH-1:0] wr_data, rd_word;
   logic [STRB_WIDTH-1:0] wr_strb;

   assign awready = !aw_cap_q && !bvalid_q;
   assign wready  = !w_cap_q && !bvalid_q;
   assign arready = !rd_pend_q;
   assign bvalid  = bvalid_q;
   assign bresp   = bresp_q;
   assign rvalid  = rvalid_q;
   assign rresp   = rresp_q;
   assign rdata   = rdata_q;

   // Zero-wait builds commit on the capture edge, so look through to the live bus
   assign wr_addr = aw_cap_q ? aw_addr_q : awaddr;
   assign wr_data = w_cap_q ? w_data_q : wdata;
   assign wr_strb = w_cap_q ? w_strb_q : wstrb;
   assign rd_addr = rd_pend_q ? ar_addr_q : araddr;
   assign wr_err  = (wr_addr == '0) || ({1'b0, wr_addr} >= REG_LIMIT);
   assign rd_err  = ({1'b0, rd_addr} >= REG_LIMIT);

   always_comb begin
      rd_word = '0;
      if (!rd_err) begin
         if (rd_addr == '0) rd_word = ID_WORD;
         for (int i = 1; i < REG_COUNT; i++) begin
            if (rd_addr == ADDR_WIDTH'(i)) rd_word = regs_q[i];
         end
      end
   end

   always_comb begin
      regs_d    = regs_q;
      aw_cap_d  = aw_cap_q;
      w_cap_d   = w_cap_q;
      aw_addr_d = aw_addr_q;
      w_data_d  = w_data_q;
      w_strb_d  = w_strb_q;
      wr_cnt_d  = wr_cnt_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      rd_pend_d = rd_pend_q;
      ar_addr_d = ar_addr_q;
      rd_cnt_d  = rd_cnt_q;
      rvalid_d  = rvalid_q;
      rresp_d   = rresp_q;
      rdata_d   = rdata_q;
      wr_fire   = 1'b0;
      rd_fire   = 1'b0;

      if (awvalid && awready) begin
         aw_cap_d  = 1'b1;
         aw_addr_d = awaddr;
      end
      if (wvalid && wready) begin
         w_cap_d  = 1'b1;
         w_data_d = wdata;
         w_strb_d = wstrb;
      end
      if (!(aw_cap_q && w_cap_q) && aw_cap_d && w_cap_d) begin
         if (WAIT_CYCLES == 0) wr_fire  = 1'b1;
         else                  wr_cnt_d = WAIT_LOAD;
      end else if (wr_cnt_q != 4'd0) begin
         wr_cnt_d = wr_cnt_q - 4'd1;
         if (wr_cnt_q == 4'd1) wr_fire = 1'b1;
      end
      if (wr_fire) begin
         bvalid_d = 1'b1;
         bresp_d  = wr_err ? RESP_SLVERR : RESP_OKAY;
         for (int i = 1; i < REG_COUNT; i++) begin
            if (wr_addr == ADDR_WIDTH'(i)) begin
               for (int b = 0; b < STRB_WIDTH; b++) begin
                  if (wr_strb[b]) regs_d[i][8*b +: 8] = wr_data[8*b +: 8];
               end
            end
         end
      end
      if (bvalid_q && bready) begin
         bvalid_d = 1'b0;
         aw_cap_d = 1'b0;
         w_cap_d  = 1'b0;
      end

      if (arvalid && arready) begin
         rd_pend_d = 1'b1;
         ar_addr_d = araddr;
         if (WAIT_CYCLES == 0) rd_fire  = 1'b1;
         else                  rd_cnt_d = WAIT_LOAD;
      end else if (rd_cnt_q != 4'd0) begin
         rd_cnt_d = rd_cnt_q - 4'd1;
         if (rd_cnt_q == 4'd1) rd_fire = 1'b1;
      end
      if (rd_fire) begin
         rvalid_d = 1'b1;
         rresp_d  = rd_err ? RESP_SLVERR : RESP_OKAY;
         rdata_d  = rd_word;
      end
      if (rvalid_q && rready) begin
         rvalid_d  = 1'b0;
         rd_pend_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 1; i < REG_COUNT; i++) regs_q[i] <= '0;
         aw_cap_q  <= 1'b0;
         w_cap_q   <= 1'b0;
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         wr_cnt_q  <= 4'd0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         rd_pend_q <= 1'b0;
         ar_addr_q <= '0;
         rd_cnt_q  <= 4'd0;
         rvalid_q  <= 1'b0;
         rresp_q   <= RESP_OKAY;
         rdata_q   <= '0;
      end else begin
         regs_q    <= regs_d;
         aw_cap_q  <= aw_cap_d;
         w_cap_q   <= w_cap_d;
         aw_addr_q <= aw_addr_d;
         w_data_q  <= w_data_d;
         w_strb_q  <= w_strb_d;
         wr_cnt_q  <= wr_cnt_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         rd_pend_q <= rd_pend_d;
         ar_addr_q <= ar_addr_d;
         rd_cnt_q  <= rd_cnt_d;
         rvalid_q  <= rvalid_d;
         rresp_q   <= rresp_d;
         rdata_q   <= rdata_d;
      end
   end
endmodule

// File: tb/tb_axi4lite_cmd_bridge.sv
// Directed bench for axi4lite_cmd_bridge: a zero-wait instance driven from a vector table,
// plus a WAIT_CYCLES=3 instance for the backpressure sequence.
module tb_axi4lite_cmd_bridge;
   logic clk = 1'b0;
   logic rst_n;
   logic ena, ena2;
   logic busy, busy2;
   int   checks   = 0;
   int   failures = 0;

`ifdef AXI4LITE_STRB_EN
   localparam bit STRB_ON = 1'b1;
`else
   localparam bit STRB_ON = 1'b0;
`endif

   always #5 clk = ~clk;

   axi4lite_cmd_bridge_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus ();
   axi4lite_cmd_bridge_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus2 ();

   axi4lite_cmd_bridge #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .REG_COUNT(12), .WAIT_CYCLES(0)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .busy(busy), .bus(bus)
   );

   axi4lite_cmd_bridge #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .REG_COUNT(12), .WAIT_CYCLES(3)) dut2 (
      .clk(clk), .rst_n(rst_n), .ena(ena2), .busy(busy2), .bus(bus2)
   );

   typedef struct {
      logic        wr;
      logic [3:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [1:0]  resp;
      logic [31:0] rdata;
   } vec_t;

   vec_t vecs [18];

   function automatic vec_t mk(logic wr, logic [3:0] addr, logic [31:0] wd, logic [3:0] st,
                               logic [1:0] resp, logic [31:0] rd);
      vec_t v;
      v.wr = wr; v.addr = addr; v.wdata = wd; v.wstrb = st; v.resp = resp; v.rdata = rd;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Issue one command on the zero-wait instance; returns edges from accept to rsp_valid
   task automatic issue(input logic wr, input logic [3:0] addr, input logic [31:0] wd,
                        input logic [3:0] st, input bit drop_ena, output int lat);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.cmd_ready && n < 50) begin @(negedge clk); n++; end
      if (!bus.cmd_ready) check("accept_timeout", 32'd0, 32'd1);
      bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = addr;
      bus.cmd_wdata = wd;   bus.cmd_wstrb = st;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      if (drop_ena) ena = 1'b0;
      lat = 0;
      while (!bus.rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
      if (!bus.rsp_valid) check("rsp_timeout", 32'd0, 32'd1);
   endtask

   task automatic issue2(input logic wr, input logic [3:0] addr, input logic [31:0] wd,
                         input logic [3:0] st, output int lat);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus2.cmd_ready && n < 50) begin @(negedge clk); n++; end
      if (!bus2.cmd_ready) check("accept2_timeout", 32'd0, 32'd1);
      bus2.cmd_valid = 1'b1; bus2.cmd_write = wr; bus2.cmd_addr = addr;
      bus2.cmd_wdata = wd;   bus2.cmd_wstrb = st;
      @(posedge clk); #1;
      bus2.cmd_valid = 1'b0;
      lat = 0;
      while (!bus2.rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
      if (!bus2.rsp_valid) check("rsp2_timeout", 32'd0, 32'd1);
   endtask

   task automatic consume();
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
   endtask

   task automatic read_expect(input string name, input logic [3:0] addr, input logic [31:0] exp);
      int lat;
      issue(1'b0, addr, 32'h0, 4'h0, 1'b0, lat);
      check({name, "_resp"}, 32'(bus.rsp_resp), 32'h0);
      check({name, "_rdata"}, bus.rsp_rdata, exp);
      $display("txn read addr=%0d rdata=%h lat=%0d", addr, bus.rsp_rdata, lat);
      consume();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat;
      int acc [$];
      int n;
      logic saw_rsp;
      logic [31:0] rd_strb5;

      rd_strb5 = STRB_ON ? 32'h11BB_33DD : 32'hAABB_CCDD;
      vecs[0]  = mk(1'b0, 4'd0,  32'h0,         4'h0, 2'b00, 32'hA41C_0001);
      vecs[1]  = mk(1'b1, 4'd2,  32'h1122_3344, 4'hF, 2'b00, 32'h0);
      vecs[2]  = mk(1'b0, 4'd2,  32'h0,         4'h0, 2'b00, 32'h1122_3344);
      vecs[3]  = mk(1'b1, 4'd2,  32'hAABB_CCDD, 4'h5, 2'b00, 32'h0);
      vecs[4]  = mk(1'b0, 4'd2,  32'h0,         4'h0, 2'b00, rd_strb5);
      vecs[5]  = mk(1'b1, 4'd0,  32'hFFFF_FFFF, 4'hF, 2'b10, 32'h0);
      vecs[6]  = mk(1'b0, 4'd0,  32'h0,         4'h0, 2'b00, 32'hA41C_0001);
      vecs[7]  = mk(1'b1, 4'd13, 32'h1234_5678, 4'hF, 2'b10, 32'h0);
      vecs[8]  = mk(1'b0, 4'd13, 32'h0,         4'h0, 2'b10, 32'h0);
      vecs[9]  = mk(1'b1, 4'd5,  32'hDEAD_BEEF, 4'h0, 2'b00, 32'h0);
      vecs[10] = mk(1'b0, 4'd5,  32'h0,         4'h0, 2'b00, STRB_ON ? 32'h0 : 32'hDEAD_BEEF);
      vecs[11] = mk(1'b1, 4'd11, 32'hCAFE_F00D, 4'hF, 2'b00, 32'h0);
      vecs[12] = mk(1'b0, 4'd11, 32'h0,         4'h0, 2'b00, 32'hCAFE_F00D);
      vecs[13] = mk(1'b1, 4'd12, 32'h5555_5555, 4'hF, 2'b10, 32'h0);
      vecs[14] = mk(1'b0, 4'd12, 32'h0,         4'h0, 2'b10, 32'h0);
      vecs[15] = mk(1'b0, 4'd1,  32'h0,         4'h0, 2'b00, 32'h0);
      vecs[16] = mk(1'b0, 4'd4,  32'h0,         4'h0, 2'b00, 32'h0);
      vecs[17] = mk(1'b0, 4'd2,  32'h0,         4'h0, 2'b00, rd_strb5);

      rst_n = 1'b0; ena = 1'b1; ena2 = 1'b1;
      bus.cmd_valid = 1'b0;  bus.cmd_write = 1'b0;  bus.cmd_addr = '0;
      bus.cmd_wdata = '0;    bus.cmd_wstrb = '0;    bus.rsp_ready = 1'b0;
      bus2.cmd_valid = 1'b0; bus2.cmd_write = 1'b0; bus2.cmd_addr = '0;
      bus2.cmd_wdata = '0;   bus2.cmd_wstrb = '0;   bus2.rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rsp_resp", 32'(bus.rsp_resp), 32'd0);
      check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 18; i++) begin
         issue(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, 1'b0, lat);
         check($sformatf("v%0d_lat", i), 32'(lat), 32'd2);
         check($sformatf("v%0d_write", i), 32'(bus.rsp_write), 32'(vecs[i].wr));
         check($sformatf("v%0d_resp", i), 32'(bus.rsp_resp), 32'(vecs[i].resp));
         check($sformatf("v%0d_rdata", i), bus.rsp_rdata, vecs[i].rdata);
         $display("txn %0d wr=%0d addr=%0d resp=%0h rdata=%h lat=%0d",
                  i, vecs[i].wr, vecs[i].addr, bus.rsp_resp, bus.rsp_rdata, lat);
         consume();
         check($sformatf("v%0d_ready_after", i), 32'(bus.cmd_ready), 32'd1);
      end

      // Back-to-back reads with rsp_ready held high
      bus.cmd_write = 1'b0; bus.cmd_addr = 4'd1; bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      for (int c = 0; c < 14; c++) begin
         if (bus.cmd_ready && bus.cmd_valid) acc.push_back(c);
         @(negedge clk);
      end
      bus.cmd_valid = 1'b0;
      n = 0;
      while (busy && n < 20) begin @(negedge clk); n++; end
      bus.rsp_ready = 1'b0;
      check("tput_count", 32'(acc.size()), 32'd4);
      for (int k = 1; k < acc.size(); k++) check("tput_gap", 32'(acc[k] - acc[k-1]), 32'd4);
      $display("txn throughput accepts=%0d", acc.size());

      // ena dropped right after accept: response still delivered
      issue(1'b1, 4'd3, 32'h0000_3333, 4'hF, 1'b1, lat);
      check("ena_lat", 32'(lat), 32'd2);
      check("ena_resp", 32'(bus.rsp_resp), 32'd0);
      check("ena_write", 32'(bus.rsp_write), 32'd1);
      $display("txn ena-drop write resp=%0h lat=%0d", bus.rsp_resp, lat);
      consume();
      check("ena_low_ready", 32'(bus.cmd_ready), 32'd0);
      bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 4'd3;
      repeat (3) @(posedge clk);
      #1;
      check("ena_low_no_accept", 32'(busy), 32'd0);
      bus.cmd_valid = 1'b0;
      ena = 1'b1;
      read_expect("ena_readback", 4'd3, 32'h0000_3333);

      // Reset while in WR_RESP
      @(negedge clk);
      bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 4'd2;
      bus.cmd_wdata = 32'h0000_0077; bus.cmd_wstrb = 4'hF;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      @(posedge clk); #1;
      check("wr_resp_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("arst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      check("arst_rsp_write", 32'(bus.rsp_write), 32'd0);
      check("arst_rsp_rdata", bus.rsp_rdata, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      saw_rsp = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
         if (bus.rsp_valid) saw_rsp = 1'b1;
      end
      check("arst_no_rsp", 32'(saw_rsp), 32'd0);
      $display("txn reset-abort write addr=2");
      read_expect("arst_word2", 4'd2, 32'h0);
      read_expect("arst_word3", 4'd3, 32'h0);
      read_expect("arst_word11", 4'd11, 32'h0);

      // WAIT_CYCLES=3 instance with rsp_ready held low
      issue2(1'b1, 4'd4, 32'h0000_0044, 4'hF, lat);
      check("w3_lat", 32'(lat), 32'd5);
      for (int c = 0; c < 5; c++) begin
         check("w3_hold_valid", 32'(bus2.rsp_valid), 32'd1);
         check("w3_hold_resp", 32'(bus2.rsp_resp), 32'd0);
         check("w3_hold_write", 32'(bus2.rsp_write), 32'd1);
         check("w3_hold_ready", 32'(bus2.cmd_ready), 32'd0);
         @(posedge clk); #1;
      end
      bus2.rsp_ready = 1'b1;
      check("w3_ready_before_edge", 32'(bus2.cmd_ready), 32'd0);
      @(posedge clk); #1;
      bus2.rsp_ready = 1'b0;
      check("w3_ready_after", 32'(bus2.cmd_ready), 32'd1);
      check("w3_valid_after", 32'(bus2.rsp_valid), 32'd0);
      $display("txn wait3 write addr=4 lat=%0d", lat);
      issue2(1'b0, 4'd4, 32'h0, 4'h0, lat);
      check("w3_rd_lat", 32'(lat), 32'd5);
      check("w3_rd_rdata", bus2.rsp_rdata, 32'h0000_0044);
      check("w3_rd_write", 32'(bus2.rsp_write), 32'd0);
      $display("txn wait3 read addr=4 rdata=%h lat=%0d", bus2.rsp_rdata, lat);
      bus2.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus2.rsp_ready = 1'b0;
      issue2(1'b1, 4'd0, 32'hFFFF_FFFF, 4'hF, lat);
      check("w3_id_wr_resp", 32'(bus2.rsp_resp), 32'h2);
      $display("txn wait3 write addr=0 resp=%0h", bus2.rsp_resp);
      bus2.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus2.rsp_ready = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
